// File: rtl/seq_arith_pkg.sv
// rtl/seq_arith_pkg.sv - shared state and mode encodings for seq_arith_unit
package seq_arith_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic MODE_GCD = 1'b0;
  localparam logic MODE_MUL = 1'b1;

endpackage

// File: rtl/seq_arith_ctrl.sv
// rtl/seq_arith_ctrl.sv - IDLE/RUN/DONE controller with saturating RUN-cycle counter
module seq_arith_ctrl
  import seq_arith_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic          a_zero_i,
  input  logic          b_zero_i,
  input  logic          iteration_last_i,
  output logic          load_o,
  output logic          step_o,
  output logic          finish_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] cycles_o
);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic [CW-1:0] cnt_inc;
  logic          finish_cond;

  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  assign finish_cond = (mode_i == MODE_MUL) ? iteration_last_i : (a_zero_i | b_zero_i);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    load_o   = 1'b0;
    finish_o = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          load_o  = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // the finishing cycle itself is included in the reported count
        if (finish_cond) begin
          finish_o = 1'b1;
          cycles_d = cnt_inc;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
    end
  end

  assign step_o   = (state_q == ST_RUN);
  assign busy_o   = (state_q == ST_RUN);
  assign done_o   = (state_q == ST_DONE);
  assign cycles_o = cycles_q;

endmodule

// File: rtl/seq_arith_unit.sv
// rtl/seq_arith_unit.sv - iterative binary-GCD / shift-add multiplier with Start/Done handshake
module seq_arith_unit
  import seq_arith_pkg::*;
#(
  parameter int K  = 16,
  parameter int CW = $clog2(3*K) + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [K-1:0]  A,
  input  logic [K-1:0]  B,
  input  logic          Mode,
  input  logic          Start,
  output logic          Busy,
  output logic          Done,
  output logic [K-1:0]  C,
  output logic          Ovf,
  output logic          Zin,
  output logic [CW-1:0] Cycles
);

  localparam int SW = $clog2(K) + 1;

  logic [K-1:0]   a_q, a_d;
  logic [K-1:0]   b_q, b_d;
  logic           mode_q, mode_d;
  logic [SW-1:0]  s_q, s_d;
  logic [2*K-1:0] acc_q, acc_d;
  logic [K-1:0]   c_q, c_d;
  logic           ovf_q, ovf_d;
  logic           zin_q, zin_d;
  logic [2*K-1:0] prod;

  logic load, step, finish;
  logic a_zero, b_zero, iteration_last;

  assign a_zero         = (a_q == '0);
  assign b_zero         = (b_q == '0);
  assign iteration_last = (s_q == SW'(K-1));

  seq_arith_ctrl #(.CW(CW)) u_ctrl (
    .clk              (clk),
    .reset            (reset),
    .start_i          (Start),
    .mode_i           (mode_q),
    .a_zero_i         (a_zero),
    .b_zero_i         (b_zero),
    .iteration_last_i (iteration_last),
    .load_o           (load),
    .step_o           (step),
    .finish_o         (finish),
    .busy_o           (Busy),
    .done_o           (Done),
    .cycles_o         (Cycles)
  );

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    mode_d = mode_q;
    s_d    = s_q;
    acc_d  = acc_q;
    c_d    = c_q;
    ovf_d  = ovf_q;
    zin_d  = zin_q;
    prod   = '0;
    if (load) begin
      a_d    = A;
      b_d    = B;
      mode_d = Mode;
      s_d    = '0;
      acc_d  = '0;
      zin_d  = (A == '0) || (B == '0);
    end else if (step) begin
      if (mode_q == MODE_MUL) begin
        // b is consumed LSB-first, so b_q[0] is multiplier bit s_q
        prod  = acc_q + (b_q[0] ? ({{K{1'b0}}, a_q} << s_q) : '0);
        acc_d = prod;
        b_d   = b_q >> 1;
        s_d   = s_q + SW'(1);
        if (finish) begin
          c_d   = prod[K-1:0];
          ovf_d = |prod[2*K-1:K];
        end
      end else begin
        if (a_zero) begin
          c_d   = b_q << s_q;
          ovf_d = 1'b0;
        end else if (b_zero) begin
          c_d   = a_q << s_q;
          ovf_d = 1'b0;
        end else if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          s_d = s_q + SW'(1);
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q >= b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= MODE_GCD;
      s_q    <= '0;
      acc_q  <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zin_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      mode_q <= mode_d;
      s_q    <= s_d;
      acc_q  <= acc_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      zin_q  <= zin_d;
    end
  end

  assign C   = c_q;
  assign Ovf = ovf_q;
  assign Zin = zin_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// tb/tb_seq_arith_unit.sv - directed self-checking bench for seq_arith_unit
module tb_seq_arith_unit;

  localparam int K  = 16;
  localparam int CW = $clog2(3*K) + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [K-1:0]  A = '0;
  logic [K-1:0]  B = '0;
  logic          Mode = 1'b0;
  logic          Start = 1'b0;
  logic          Busy, Done, Ovf, Zin;
  logic [K-1:0]  C;
  logic [CW-1:0] Cycles;

  int checks = 0;
  int failures = 0;

  seq_arith_unit #(.K(K), .CW(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .Mode   (Mode),
    .Start  (Start),
    .Busy   (Busy),
    .Done   (Done),
    .C      (C),
    .Ovf    (Ovf),
    .Zin    (Zin),
    .Cycles (Cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [K-1:0] a, input logic [K-1:0] b, input logic m);
    @(negedge clk);
    A = a; B = b; Mode = m; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (Done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [K-1:0] a, input logic [K-1:0] b,
                        input logic m, input logic [31:0] exp_c);
    launch(a, b, m);
    wait_done(tag);
    check({tag, "_C"}, 32'(C), exp_c);
  endtask

  initial begin
    #12;
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_c", 32'(C), 0);
    check("rst_cycles", 32'(Cycles), 0);
    @(negedge clk);
    reset = 1'b0;

    // GCD(48,18): Busy visible the cycle after acceptance
    launch(16'd48, 16'd18, 1'b0);
    check("g48_busy", 32'(Busy), 1);
    check("g48_notdone", 32'(Done), 0);
    wait_done("g48");
    check("g48_C", 32'(C), 6);
    check("g48_zin", 32'(Zin), 0);
    check("g48_ovf", 32'(Ovf), 0);
    check("g48_busylow", 32'(Busy), 0);
    check("g48_cycles", 32'(Cycles), 8);

    run_op("g0_35", 16'd0, 16'd35, 1'b0, 35);
    check("g0_35_zin", 32'(Zin), 1);
    check("g0_35_cycles", 32'(Cycles), 1);
    run_op("g0_0", 16'd0, 16'd0, 1'b0, 0);
    check("g0_0_zin", 32'(Zin), 1);
    run_op("gmax", 16'hFFFF, 16'hFFFF, 1'b0, 65535);
    check("gmax_cycles", 32'(Cycles), 2);
    run_op("g1024", 16'd1024, 16'd768, 1'b0, 256);
    check("g1024_cycles", 32'(Cycles), 14);

    run_op("m300x200", 16'd300, 16'd200, 1'b1, 60000);
    check("m300x200_ovf", 32'(Ovf), 0);
    check("m300x200_cycles", 32'(Cycles), 16);
    check("m300x200_zin", 32'(Zin), 0);
    run_op("m300x300", 16'd300, 16'd300, 1'b1, 24464);
    check("m300x300_ovf", 32'(Ovf), 1);

    // Start pulsed during RUN must not disturb the running GCD
    launch(16'd48, 16'd18, 1'b0);
    @(negedge clk);
    A = 16'd5; B = 16'd5; Mode = 1'b1; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_done("midstart");
    check("midstart_C", 32'(C), 6);
    check("midstart_cycles", 32'(Cycles), 8);

    // Start held high while in DONE restarts on the next edge
    @(negedge clk);
    check("held_done_before", 32'(Done), 1);
    A = 16'd300; B = 16'd200; Mode = 1'b1; Start = 1'b1;
    @(negedge clk);
    check("held_done_drop", 32'(Done), 0);
    check("held_busy", 32'(Busy), 1);
    Start = 1'b0;
    wait_done("held");
    check("held_C", 32'(C), 60000);

    // asynchronous reset between edges during a MUL
    launch(16'd300, 16'd300, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(Busy), 0);
    check("arst_done", 32'(Done), 0);
    check("arst_c", 32'(C), 0);
    check("arst_cycles", 32'(Cycles), 0);
    check("arst_ovf", 32'(Ovf), 0);
    check("arst_zin", 32'(Zin), 0);
    @(negedge clk);
    reset = 1'b0;
    run_op("post_rst", 16'd48, 16'd18, 1'b0, 6);
    check("post_rst_cycles", 32'(Cycles), 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
- Parametrised multi-mode iterative arithmetic unit with a Start/Done handshake.
- Successor to the fixed-width 16-bit Start/Done datapath-plus-controller Top.
- Adds selectable GCD (binary/Stein) or MUL (shift-add) operation, overflow and zero-operand flags, and a cycle-count readout.
- Instantiated under a top-level wrapper driven by file-based test benches.

Parameters:
- K, 16, operand and result width (K >= 4).
- CW, $clog2(3*K)+2, width of the Cycles output.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- A  input  K  operand A, sampled on Start acceptance.
- B  input  K  operand B, sampled on Start acceptance.
- Mode  input  1  0 = GCD, 1 = MUL; sampled on Start acceptance.
- Start  input  1  request a new operation (level-sampled).
- Busy  output  1  high while computing.
- Done  output  1  result valid; held until the next accepted Start.
- C  output  K  result.
- Ovf  output  1  MUL only: product exceeded K bits.
- Zin  output  1  at least one operand was zero.
- Cycles  output  CW  number of RUN cycles taken by the last operation.

Behaviour:
- One clock (clk); reset is asynchronous, active-high.
- While reset is high: FSM goes to IDLE; Busy, Done, Ovf, Zin = 0; C = 0; Cycles = 0; internal registers = 0.
- Reset mid-operation aborts the operation; no partial result is retained.
- FSM states: IDLE, RUN, DONE.
- IDLE / DONE with Start = 1 at a clock edge:
  - Latch A, B, Mode into working registers a, b.
  - Clear shift count s and the cycle counter.
  - Set Zin = (A==0 || B==0).
  - Next state RUN; Busy = 1, Done = 0 from the following cycle.
- Start while in RUN is ignored.
- RUN, GCD, one step per cycle, evaluated in priority order:
  - a==0: result = b<<s, finish.
  - b==0: result = a<<s, finish.
  - a and b both even: a>>=1, b>>=1, s++.
  - a even: a>>=1.
  - b even: b>>=1.
  - both odd: if a>=b then a=a-b, else b=b-a.
- GCD arithmetic rules:
  - gcd(0,0) = 0; gcd(x,0) = x.
  - Result always fits in K bits; Ovf = 0.
  - Worst case is bounded by 3K RUN cycles.
- RUN, MUL (shift-add):
  - 2K-bit accumulator; exactly K iterations.
  - Iteration i: if multiplier bit i = 1, add multiplicand << i.
  - C = low K bits of the product; Ovf = OR of the high K bits.
- Finish:
  - C, Ovf and Cycles (RUN cycles including the finishing cycle) are registered on the finishing edge.
  - State goes to DONE: Done = 1, Busy = 0 from the next cycle.
  - C and Cycles are stable until the next finish or reset.
- Cycles saturates at its maximum value; it never wraps.
- DONE with Start = 0: stay in DONE, Done held high.
- Busy and Done are never high simultaneously.

Decomposition:
- Shared package (seq_arith_pkg):
  - State encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Mode constants: MODE_GCD = 1'b0, MODE_MUL = 1'b1.
- Sub-module seq_arith_ctrl: the FSM plus the cycle counter. It takes status inputs (a_zero, b_zero, iteration_last, mode) and drives load/step/finish strobes.
- The datapath (working registers, subtractor, accumulator) stays in seq_arith_unit.

Test Plan (all with K = 16):
- GCD(48,18): Start held for 1 cycle, Mode = 0 -> Done rises with C = 6, Zin = 0, Ovf = 0; Busy low once Done is high.
- GCD(0,35) -> C = 35, Zin = 1, Cycles = 1. GCD(0,0) -> C = 0, Zin = 1.
- GCD(65535,65535) -> C = 65535. GCD(1024,768) -> C = 256 (exercises s shifting).
- MUL(300,200) -> C = 60000, Ovf = 0, Cycles = 16. MUL(300,300) -> C = 24464, Ovf = 1.
- Start pulsed again mid-RUN -> ignored, first result unchanged. Start held high in DONE -> new operation starts the next cycle and Done drops.
- reset asserted during RUN of MUL(300,300), asynchronously between edges -> all outputs 0 immediately. After release, GCD(48,18) completes with C = 6.
